// File: rtl/refresh_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// refresh_frame_sequencer_if
//   Bundles the refresh tick, the per-stage start/done handshake and the
//   frame / overrun status of the refresh frame sequencer.
//
//   master : the surrounding system (tick source, stage modules, status reader)
//   slave  : the sequencer itself
//
//   Signals
//     refresh_tick   one-cycle frame tick, clk_50 domain
//     stage_done     per-stage completion, level or pulse
//     overrun_clr    clears overrun / overrun_count / stage_timeout
//     stage_start    one-hot, one-cycle start pulse to the current stage
//     busy           sequencer not idle
//     frame_done     one-cycle pulse when the last stage completes
//     frame_count    completed frames, wraps
//     overrun        sticky dropped-tick flag
//     overrun_count  dropped ticks, saturating
//     stage_timeout  sticky watchdog flag
// -----------------------------------------------------------------------------
interface refresh_frame_sequencer_if #(
   parameter int NUM_STAGES = 3,
   parameter int FRAME_W    = 16,
   parameter int OVR_W      = 8
);
   logic                  refresh_tick;
   logic [NUM_STAGES-1:0] stage_done;
   logic                  overrun_clr;
   logic [NUM_STAGES-1:0] stage_start;
   logic                  busy;
   logic                  frame_done;
   logic [FRAME_W-1:0]    frame_count;
   logic                  overrun;
   logic [OVR_W-1:0]      overrun_count;
   logic                  stage_timeout;

   modport master (
      output refresh_tick, stage_done, overrun_clr,
      input  stage_start, busy, frame_done, frame_count,
             overrun, overrun_count, stage_timeout
   );

   modport slave (
      input  refresh_tick, stage_done, overrun_clr,
      output stage_start, busy, frame_done, frame_count,
             overrun, overrun_count, stage_timeout
   );
endinterface

// File: rtl/refresh_frame_sequencer.sv
// -----------------------------------------------------------------------------
// refresh_frame_sequencer
//   Consumes the one-cycle refresh tick and runs the per-frame update stages
//   (input sample, physics, render latch, ...) strictly in order, each with a
//   start/done handshake. Counts completed frames and counts ticks that
//   arrive while a frame is still being sequenced.
//
//   Ports
//     clk_50  system clock
//     rst     synchronous reset, active-high
//     sif     refresh_frame_sequencer_if.slave (tick, stage handshake, status)
//
//   Optional feature
//     REFRESH_SEQ_WDOG_EN  when defined, a per-stage watchdog aborts a stage
//                          that has not completed within WDOG_CYCLES and sets
//                          the sticky stage_timeout flag. When undefined,
//                          stage_timeout is constant 0 and a stage may hang.
//
//   All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module refresh_frame_sequencer #(
   parameter int NUM_STAGES  = 3,
   parameter int FRAME_W     = 16,
   parameter int OVR_W       = 8,
   parameter int WDOG_CYCLES = 2000000
) (
   input logic                       clk_50,
   input logic                       rst,
   refresh_frame_sequencer_if.slave  sif
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   state_t                state;
   logic [IDX_W-1:0]      stage_idx;
   logic [NUM_STAGES-1:0] stage_start_q;
   logic                  busy_q;
   logic                  frame_done_q;
   logic [FRAME_W-1:0]    frame_count_q;
   logic                  overrun_q;
   logic [OVR_W-1:0]      overrun_count_q;
   logic                  stage_hit;
   logic                  drop;

   // Only the bit of the stage being waited on is ever looked at.
   assign stage_hit = sif.stage_done[stage_idx];
   // A tick is only accepted from IDLE; anywhere else (DONE included) it is lost.
   assign drop      = sif.refresh_tick && (state != IDLE);

   function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

`ifdef REFRESH_SEQ_WDOG_EN
   localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] wdog_cnt;
   logic            timeout_q;
`endif

   // Sequencing FSM. Outputs are registered alongside the state transition so
   // each one is valid exactly while the FSM sits in the matching state.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state         <= IDLE;
         stage_idx     <= '0;
         stage_start_q <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
`ifdef REFRESH_SEQ_WDOG_EN
         wdog_cnt      <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         stage_start_q <= '0;
         frame_done_q  <= 1'b0;
`ifdef REFRESH_SEQ_WDOG_EN
         // A timeout raised later in this block overrides this clear.
         if (sif.overrun_clr) timeout_q <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (sif.refresh_tick) begin
                  stage_idx     <= '0;
                  state         <= START;
                  stage_start_q <= NUM_STAGES'(1);
                  busy_q        <= 1'b1;
               end
            end
            START: begin
               state <= WAIT;
`ifdef REFRESH_SEQ_WDOG_EN
               wdog_cnt <= '0;
`endif
            end
            WAIT: begin
               if (stage_hit) begin
                  if (stage_idx == LAST_IDX) begin
                     state        <= DONE;
                     frame_done_q <= 1'b1;
                  end else begin
                     stage_idx     <= stage_idx + 1'b1;
                     state         <= START;
                     stage_start_q <= NUM_STAGES'(1) << (stage_idx + 1'b1);
                  end
               end
`ifdef REFRESH_SEQ_WDOG_EN
               // A done in the same cycle as expiry is taken above and wins.
               else if (wdog_cnt == WD_LAST) begin
                  state     <= IDLE;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               frame_count_q <= frame_count_q + 1'b1;
               state         <= IDLE;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   // Dropped-tick bookkeeping. A drop in the same cycle as a clear wins and
   // restarts the count at the current drop.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         overrun_q       <= 1'b0;
         overrun_count_q <= '0;
      end else if (drop) begin
         overrun_q       <= 1'b1;
         overrun_count_q <= sif.overrun_clr ? OVR_W'(1) : sat_inc(overrun_count_q);
      end else if (sif.overrun_clr) begin
         overrun_q       <= 1'b0;
         overrun_count_q <= '0;
      end
   end

   assign sif.stage_start   = stage_start_q;
   assign sif.busy          = busy_q;
   assign sif.frame_done    = frame_done_q;
   assign sif.frame_count   = frame_count_q;
   assign sif.overrun       = overrun_q;
   assign sif.overrun_count = overrun_count_q;
`ifdef REFRESH_SEQ_WDOG_EN
   assign sif.stage_timeout = timeout_q;
`else
   // Constant 0 for every legal WDOG_CYCLES; expressed through the parameter
   // so the parameter stays referenced when the watchdog is compiled out.
   assign sif.stage_timeout = (WDOG_CYCLES < 1);
`endif

endmodule

// File: tb/tb_refresh_frame_sequencer.sv
module tb_refresh_frame_sequencer;
   localparam int NS   = 3;
   localparam int FW   = 8;
   localparam int OW   = 8;
   localparam int WD   = 20;
   localparam int HANG = 1 << 28;
   localparam int OMAX = (1 << OW) - 1;

   logic clk_50 = 1'b0;
   logic rst;
   always #10 clk_50 = ~clk_50;

   refresh_frame_sequencer_if #(.NUM_STAGES(NS), .FRAME_W(FW), .OVR_W(OW)) sif ();

   refresh_frame_sequencer #(
      .NUM_STAGES(NS), .FRAME_W(FW), .OVR_W(OW), .WDOG_CYCLES(WD)
   ) dut (
      .clk_50(clk_50),
      .rst   (rst),
      .sif   (sif)
   );

   int total = 0;
   int bad   = 0;
   int e     = 0;   // index of the clock edge that samples the current inputs

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", tag, act, exp, e);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: a frame is planned as a timeline of edge numbers.
   // Stage i starts (START) after edge s_edge[i]; its done is sampled at
   // dn_edge[i] = s_edge[i] + 1 + d; the next stage starts after that edge.
   // frame_done after f_edge, count bump after f_edge+1, IDLE again after f_edge+1.
   // ---------------------------------------------------------------------------
   int  mode;      // 0 random pulses + noise, 1 done held all-ones, 2 fixed delay, 3 hang
   int  fixed_d;
   int  hang_idx;
   bit  m_active;
   int  s_edge  [NS];
   int  dn_edge [NS];
   int  f_edge, free_edge, abort_edge;
   int  m_fc, m_oc;
   bit  m_ovr, m_to;

   function automatic int pick_d(input int i);
      case (mode)
         1:       return 1;
         2:       return fixed_d;
         3:       return (i == hang_idx) ? HANG : int'($urandom_range(1, 3));
         default: return int'($urandom_range(1, 6));
      endcase
   endfunction

   task automatic plan(input int k);
      int s, d;
      s = k;
      m_active   = 1'b1;
      f_edge     = -10;
      abort_edge = -10;
      for (int i = 0; i < NS; i++) begin
         s_edge[i]  = -10;
         dn_edge[i] = -10;
      end
      for (int i = 0; i < NS; i++) begin
         s_edge[i] = s;
         d = pick_d(i);
`ifdef REFRESH_SEQ_WDOG_EN
         if (d > WD) begin
            abort_edge = s + WD + 1;
            dn_edge[i] = abort_edge;
            free_edge  = abort_edge + 1;
            return;
         end
`endif
         dn_edge[i] = s + 1 + d;
         s = dn_edge[i];
      end
      f_edge    = s;
      free_edge = s + 2;
   endtask

   function automatic bit waited(input int j);
      return m_active && (e >= s_edge[j] + 2) && (e <= dn_edge[j]);
   endfunction

   task automatic cycle(input bit tick, input bit clr, input bit do_rst);
      logic [NS-1:0] dn;
      logic [NS-1:0] x_start;
      bit idle, x_busy, x_fd;
      dn = '0;
      if (mode == 1) dn = '1;
      else begin
         for (int i = 0; i < NS; i++)
            if (m_active && e == dn_edge[i]) dn[i] = 1'b1;
         if (mode == 0)
            for (int j = 0; j < NS; j++)
               if (!waited(j) && $urandom_range(0, 3) == 0) dn[j] = 1'b1;
      end
      sif.refresh_tick = tick;
      sif.overrun_clr  = clr;
      sif.stage_done   = dn;
      rst              = do_rst;

      if (do_rst) begin
         m_active = 1'b0;
         m_fc = 0; m_oc = 0; m_ovr = 1'b0; m_to = 1'b0;
      end else begin
         idle = !(m_active && e > s_edge[0] && e < free_edge);
         if (tick && idle) plan(e);
         if (tick && !idle) begin
            m_ovr = 1'b1;
            m_oc  = clr ? 1 : ((m_oc < OMAX) ? m_oc + 1 : m_oc);
         end else if (clr) begin
            m_ovr = 1'b0;
            m_oc  = 0;
         end
         if (clr) m_to = 1'b0;
         if (m_active && e == abort_edge) m_to = 1'b1;
         if (m_active && e == f_edge + 1) m_fc = (m_fc + 1) % (1 << FW);
      end

      x_start = '0;
      for (int i = 0; i < NS; i++)
         if (m_active && e == s_edge[i]) x_start[i] = 1'b1;
      x_busy = m_active && e >= s_edge[0] && e < free_edge - 1;
      x_fd   = m_active && e == f_edge;

      @(posedge clk_50);
      @(negedge clk_50);
      chk("stage_start",   32'(sif.stage_start),   32'(x_start));
      chk("busy",          32'(sif.busy),          32'(x_busy));
      chk("frame_done",    32'(sif.frame_done),    32'(x_fd));
      chk("frame_count",   32'(sif.frame_count),   32'(m_fc));
      chk("overrun",       32'(sif.overrun),       32'(m_ovr));
      chk("overrun_count", 32'(sif.overrun_count), 32'(m_oc));
      chk("stage_timeout", 32'(sif.stage_timeout), 32'(m_to));
      e++;
   endtask

   task automatic idle_n(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      sif.refresh_tick = 1'b0;
      sif.overrun_clr  = 1'b0;
      sif.stage_done   = '0;
      rst              = 1'b1;
      m_active = 1'b0; m_fc = 0; m_oc = 0; m_ovr = 1'b0; m_to = 1'b0;
      f_edge = -10; free_edge = 0; abort_edge = -10;
      for (int i = 0; i < NS; i++) begin s_edge[i] = -10; dn_edge[i] = -10; end
      mode = 0; fixed_d = 2; hang_idx = 0;

      // reset state
      repeat (3) cycle(1'b0, 1'b0, 1'b1);

      // single frame, each done a fixed delay after its start
      mode = 2; fixed_d = 2;
      idle_n(6);
      cycle(1'b1, 1'b0, 1'b0);
      idle_n(14);
      chk("frame1_count", 32'(sif.frame_count), 32'd1);

      // done held high on every stage: minimum-length frame
      mode = 1;
      idle_n(3);
      cycle(1'b1, 1'b0, 1'b0);
      idle_n(10);
      chk("frame2_count", 32'(sif.frame_count), 32'd2);

      // stage 1 hangs; three dropped ticks, then clear together with a fourth
      mode = 3; hang_idx = 1;
      cycle(1'b1, 1'b0, 1'b0);
      idle_n(5);
      for (int t = 0; t < 3; t++) begin
         cycle(1'b1, 1'b0, 1'b0);
         idle_n(1);
      end
      chk("ovr_after3", 32'(sif.overrun_count), 32'd3);
      cycle(1'b1, 1'b1, 1'b0);
      chk("ovr_clr_drop", 32'(sif.overrun_count), 32'd1);
      chk("ovr_flag_clr_drop", 32'(sif.overrun), 32'd1);
      cycle(1'b0, 1'b0, 1'b1);

      // saturation of the dropped-tick counter
      mode = 3; hang_idx = 0;
      cycle(1'b1, 1'b0, 1'b0);
      repeat (300) cycle(1'b1, 1'b0, 1'b0);
      chk("ovr_sat", 32'(sif.overrun_count), 32'(OMAX));
      repeat (5) cycle(1'b1, 1'b0, 1'b0);
      chk("ovr_sat_hold", 32'(sif.overrun_count), 32'(OMAX));
      cycle(1'b0, 1'b1, 1'b0);
      chk("ovr_clr", 32'(sif.overrun_count), 32'd0);
      cycle(1'b0, 1'b0, 1'b1);

      // reset while waiting on the last stage, then a clean restart
      mode = 3; hang_idx = 2;
      cycle(1'b1, 1'b0, 1'b0);
      idle_n(12);
      cycle(1'b0, 1'b0, 1'b1);
      chk("rst_mid_busy", 32'(sif.busy), 32'd0);
      mode = 0;
      cycle(1'b1, 1'b0, 1'b0);
      chk("restart_stage0", 32'(sif.stage_start), 32'd1);
      idle_n(40);

      // frame counter wrap
      cycle(1'b0, 1'b0, 1'b1);
      mode = 1;
      for (int f = 0; f < (1 << FW) - 1; f++) begin
         cycle(1'b1, 1'b0, 1'b0);
         idle_n(7);
      end
      chk("fc_allones", 32'(sif.frame_count), 32'((1 << FW) - 1));
      cycle(1'b1, 1'b0, 1'b0);
      idle_n(7);
      chk("fc_wrap", 32'(sif.frame_count), 32'd0);

      // randomized traffic
      mode = 0;
      idle_n(2);
      for (int c = 0; c < 3000; c++)
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 499) == 0);
      idle_n(40);

      // done arriving exactly at watchdog expiry still completes the frame
      cycle(1'b0, 1'b0, 1'b1);
      mode = 2; fixed_d = WD;
      cycle(1'b1, 1'b0, 1'b0);
      idle_n(3 * (WD + 1) + 6);
      chk("edge_done_count", 32'(sif.frame_count), 32'd1);
      chk("edge_done_to", 32'(sif.stage_timeout), 32'd0);

      // stage 0 never completes
      mode = 3; hang_idx = 0;
      cycle(1'b1, 1'b0, 1'b0);
      idle_n(30);
`ifdef REFRESH_SEQ_WDOG_EN
      chk("wdog_timeout", 32'(sif.stage_timeout), 32'd1);
      chk("wdog_busy", 32'(sif.busy), 32'd0);
`else
      chk("wdog_timeout", 32'(sif.stage_timeout), 32'd0);
      chk("wdog_busy", 32'(sif.busy), 32'd1);
`endif
      chk("wdog_count", 32'(sif.frame_count), 32'd1);
      cycle(1'b0, 1'b1, 1'b0);
      chk("wdog_clr", 32'(sif.stage_timeout), 32'd0);
      cycle(1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/refresh_frame_sequencer.md
Name: refresh_frame_sequencer

Overview:
Consumer end of the refresh tick interface. Takes the one-cycle refresh pulse in the clk_50 domain and sequences the per-frame game update stages (input sample, physics, render latch) in strict order. Each stage uses a start/done handshake. The block counts completed frames and flags ticks that arrive while a frame is still in progress. It sits between the refresh tick generator and the game-logic stage modules.

Parameters:
NUM_STAGES, 3, number of sequenced update stages (1..8)
FRAME_W, 16, width of the completed-frame counter
OVR_W, 8, width of the saturating overrun counter
WDOG_CYCLES, 2000000, per-stage timeout in clk_50 cycles (used only with the optional feature)

Ports:
clk_50  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
refresh_tick  input  1  one-cycle frame tick, clk_50 domain
stage_done  input  NUM_STAGES  per-stage completion; level or pulse
stage_start  output  NUM_STAGES  one-hot, one-cycle start pulse to the current stage
busy  output  1  high whenever state is not IDLE
frame_done  output  1  one-cycle pulse when the last stage completes
frame_count  output  FRAME_W  completed frames, wraps
overrun  output  1  sticky: a tick was dropped
overrun_count  output  OVR_W  dropped ticks, saturates at all-ones
overrun_clr  input  1  clears overrun and overrun_count
stage_timeout  output  1  sticky watchdog flag (tied 0 when the feature is excluded)

Behaviour:
- Reset: rst sampled high at a clk_50 edge gives:
  - state IDLE, stage_idx 0
  - stage_start 0, busy 0, frame_done 0, frame_count 0
  - overrun 0, overrun_count 0, stage_timeout 0
- Reset applies from any state, including mid-frame. Any frame in progress is abandoned and produces no frame_done.
- FSM states: IDLE, START, WAIT, DONE.
  - IDLE: refresh_tick=1 gives stage_idx<=0, next START.
  - START: stage_start[stage_idx]=1 for exactly this cycle; next WAIT. stage_done is not sampled in START.
  - WAIT: only stage_done[stage_idx] is sampled; other bits are ignored.
    - If it is 1 and stage_idx==NUM_STAGES-1: next DONE.
    - If it is 1 otherwise: stage_idx++, next START.
    - If it is 0: remain in WAIT.
  - DONE: frame_done=1 for this cycle; frame_count<=frame_count+1 (mod 2^FRAME_W); next IDLE.
- All outputs are decoded from registered state. No combinational path from any input to any output.
- Latency:
  - tick sampled at edge k: stage_start[0] high during cycle k+1.
  - done sampled at edge m in WAIT: next stage_start high during cycle m+1.
  - last done sampled at edge m: frame_done high during cycle m+1.
  - Minimum frame length is 2*NUM_STAGES+1 cycles (done held high).
- Overrun:
  - refresh_tick=1 in any state other than IDLE: tick dropped, overrun<=1, overrun_count++ saturating at 2^OVR_W-1.
  - A tick in DONE is also dropped; the next frame starts only from IDLE.
  - overrun_clr=1 with no simultaneous drop: overrun<=0, overrun_count<=0.
  - overrun_clr and a drop in the same cycle: overrun<=1, overrun_count<=1 (the set wins and counts the current drop).
- stage_done held high continuously: each stage completes one cycle after its start. It does not skip stages, because only the indexed bit is sampled in WAIT.
- NUM_STAGES=1: IDLE, START, WAIT, DONE, IDLE.

Optional Feature:
Macro REFRESH_SEQ_WDOG_EN.
- Defined:
  - A per-stage cycle counter clears in START and increments in WAIT.
  - If it reaches WDOG_CYCLES-1 with stage_done[stage_idx]=0:
    - stage_timeout<=1 (sticky, cleared by overrun_clr or rst);
    - state goes to IDLE with no frame_done and no frame_count increment.
  - If the done arrives in the same cycle as the timeout, done wins.
- Not defined: no counter logic; stage_timeout is constant 0; a stage may hang indefinitely, and every later tick is counted as an overrun.

Test Plan:
- Reset, NUM_STAGES=3, tick at edge 10, each done asserted 2 cycles after its start for 1 cycle -> stage_start = 3'b001, 3'b010, 3'b100 in order, each one cycle wide; frame_done one cycle after the third done; frame_count=1; busy low afterwards.
- stage_done tied to 3'b111, tick at edge 5 -> stage_start pulses at cycles 6, 8, 10; frame_done at cycle 12; frame_count=1.
- Stage 1 held not-done, 3 further ticks arrive -> overrun=1, overrun_count=3. Then overrun_clr together with a 4th tick -> overrun=1, overrun_count=1.
- 300 ticks dropped with OVR_W=8 -> overrun_count=255, stays 255. frame_count preset to 16'hFFFF by running 65535 frames, one more frame -> frame_count=0.
- rst asserted for 1 cycle while in WAIT on stage 2 -> next cycle all outputs 0, no frame_done; following tick restarts at stage_start[0].
- REFRESH_SEQ_WDOG_EN with WDOG_CYCLES=20, stage 0 never done -> stage_timeout=1 and busy=0 about 20 cycles after start, frame_count unchanged. Without the macro -> stage_timeout stays 0 and busy stays 1.
